// File: rtl/tsu_axis_rx.sv
// RX timestamp unit: one-cycle AXIS passthrough plus a small FIFO of {msg_type, seq_id, time}
// for good PTP event frames. Define TSU_RX_VLAN_EN to accept one 802.1Q tag ahead of the EtherType.
module tsu_axis_rx #(
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [63:0] TS_LATENCY_NS = 64'd0,
  parameter logic [15:0] PTP_ETHERTYPE = 16'h88F7
) (
  input  logic        mac_axis_aclk,
  input  logic        rst_n,
  input  logic [7:0]  mac_axis_tdata,
  input  logic        mac_axis_tvalid,
  input  logic        mac_axis_tlast,
  input  logic        mac_axis_tuser,
  input  logic [63:0] rtc_timer_in,
  output logic [7:0]  mac_axis_out_tdata,
  output logic        mac_axis_out_tvalid,
  output logic        mac_axis_out_tlast,
  output logic        mac_axis_out_tuser,
  output logic        ts_valid,
  input  logic        ts_ready,
  output logic [63:0] ts_time,
  output logic [15:0] ts_seq_id,
  output logic [3:0]  ts_msg_type,
  output logic        ts_overflow,
  output logic [15:0] ts_drop_count
);
`ifdef TSU_RX_VLAN_EN
  localparam bit VLAN_EN = 1'b1;
`else
  localparam bit VLAN_EN = 1'b0;
`endif
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, HDR, PAYLOAD, DISCARD} state_t;

  typedef struct packed {
    logic [3:0]  msg_type;
    logic [15:0] seq_id;
    logic [63:0] ts;
  } ts_entry_t;

  always_ff @(posedge mac_axis_aclk) begin
    if (!rst_n) begin
      mac_axis_out_tdata  <= '0;
      mac_axis_out_tvalid <= 1'b0;
      mac_axis_out_tlast  <= 1'b0;
      mac_axis_out_tuser  <= 1'b0;
    end else begin
      mac_axis_out_tdata  <= mac_axis_tdata;
      mac_axis_out_tvalid <= mac_axis_tvalid;
      mac_axis_out_tlast  <= mac_axis_tlast;
      mac_axis_out_tuser  <= mac_axis_tuser;
    end
  end

  state_t      state;
  logic [10:0] cnt;
  logic        vlan;
  logic [7:0]  eth_hi;
  logic [3:0]  msg_r;
  logic [15:0] seq_r;
  logic [63:0] ts_lat;
  logic [10:0] off;
  logic [15:0] eth;

  // A tag shifts every header field after the MAC addresses by four bytes.
  assign off = vlan ? 11'd4 : 11'd0;
  assign eth = {eth_hi, mac_axis_tdata};

  always_ff @(posedge mac_axis_aclk) begin
    if (!rst_n) begin
      state  <= WAIT_IDLE;
      cnt    <= '0;
      vlan   <= 1'b0;
      eth_hi <= '0;
      msg_r  <= '0;
      seq_r  <= '0;
      ts_lat <= '0;
    end else begin
      case (state)
        WAIT_IDLE: begin
          if (!mac_axis_tvalid || mac_axis_tlast) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        IDLE: begin
          if (mac_axis_tvalid) begin
            ts_lat <= rtc_timer_in;
            vlan   <= 1'b0;
            cnt    <= mac_axis_tlast ? 11'd0 : 11'd1;
            if (!mac_axis_tlast) state <= HDR;
          end
        end
        default: begin
          if (mac_axis_tvalid) begin
            cnt <= mac_axis_tlast ? 11'd0 : ((cnt == 11'h7FF) ? cnt : cnt + 11'd1);
            if (mac_axis_tlast) begin
              state <= IDLE;
            end else if (state == HDR) begin
              if (cnt == 11'd12 + off) eth_hi <= mac_axis_tdata;
              if (cnt == 11'd13 + off && eth != PTP_ETHERTYPE) begin
                if (VLAN_EN && !vlan && eth == 16'h8100) vlan <= 1'b1;
                else state <= DISCARD;
              end
              if (cnt == 11'd14 + off) begin
                msg_r <= mac_axis_tdata[3:0];
                if (mac_axis_tdata[3:0] > 4'd3) state <= DISCARD;
              end
              if (cnt == 11'd44 + off) seq_r[15:8] <= mac_axis_tdata;
              if (cnt == 11'd45 + off) begin
                seq_r[7:0] <= mac_axis_tdata;
                state      <= PAYLOAD;
              end
            end
          end
        end
      endcase
    end
  end

  logic      push;
  ts_entry_t new_entry;

  // A frame ending exactly on the last seq_id byte still carries a full header.
  always_comb begin
    push               = 1'b0;
    new_entry.msg_type = msg_r;
    new_entry.seq_id   = seq_r;
    new_entry.ts       = ts_lat + TS_LATENCY_NS;
    if (mac_axis_tvalid && mac_axis_tlast && !mac_axis_tuser) begin
      if (state == PAYLOAD) begin
        push = 1'b1;
      end else if (state == HDR && cnt == 11'd45 + off) begin
        push             = 1'b1;
        new_entry.seq_id = {seq_r[15:8], mac_axis_tdata};
      end
    end
  end

  ts_entry_t     mem [FIFO_DEPTH];
  logic [AW-1:0] wr_idx, rd_idx, rd_nxt;
  logic [AW:0]   count, count_nxt;
  logic          pop, full, accept, drop;
  ts_entry_t     head_nxt;

  always_comb begin
    pop       = ts_valid && ts_ready;
    full      = (count == FULL_CNT);
    accept    = push && (!full || pop);
    drop      = push && full && !pop;
    count_nxt = count + (AW+1)'(accept) - (AW+1)'(pop);
    rd_nxt    = rd_idx + AW'(pop);
    head_nxt  = (accept && wr_idx == rd_nxt) ? new_entry : mem[rd_nxt];
  end

  always_ff @(posedge mac_axis_aclk) begin
    if (accept) mem[wr_idx] <= new_entry;
  end

  // Head fields only reload when an entry will be present, so they hold while stalled.
  always_ff @(posedge mac_axis_aclk) begin
    if (!rst_n) begin
      wr_idx        <= '0;
      rd_idx        <= '0;
      count         <= '0;
      ts_valid      <= 1'b0;
      ts_time       <= '0;
      ts_seq_id     <= '0;
      ts_msg_type   <= '0;
      ts_overflow   <= 1'b0;
      ts_drop_count <= '0;
    end else begin
      if (accept) wr_idx <= wr_idx + AW'(1);
      rd_idx   <= rd_nxt;
      count    <= count_nxt;
      ts_valid <= (count_nxt != '0);
      if (count_nxt != '0) {ts_msg_type, ts_seq_id, ts_time} <= head_nxt;
      if (drop) begin
        ts_overflow <= 1'b1;
        if (ts_drop_count != 16'hFFFF) ts_drop_count <= ts_drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tsu_axis_rx.sv
// Randomized bench for tsu_axis_rx against a frame-level reference model and an entry queue.
module tb_tsu_axis_rx;
  localparam int          DEPTH = 4;
  localparam logic [63:0] LAT_B = 64'hFFFF_FFFF_FFFF_FF00;
`ifdef TSU_RX_VLAN_EN
  localparam bit VLAN_EN = 1'b1;
`else
  localparam bit VLAN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, tvalid, tlast, tuser, ts_ready;
  logic [7:0]  tdata;
  logic [63:0] rtc;
  logic [7:0]  o_tdata, b_tdata;
  logic        o_tvalid, o_tlast, o_tuser, b_tvalid, b_tlast, b_tuser;
  logic        ts_valid, ts_overflow, b_valid, b_overflow;
  logic [63:0] ts_time, b_time;
  logic [15:0] ts_seq_id, ts_drop_count, b_seq_id, b_drop_count;
  logic [3:0]  ts_msg_type, b_msg_type;

  tsu_axis_rx #(.FIFO_DEPTH(DEPTH), .TS_LATENCY_NS(64'd0), .PTP_ETHERTYPE(16'h88F7)) dut (
    .mac_axis_aclk(clk), .rst_n(rst_n), .mac_axis_tdata(tdata), .mac_axis_tvalid(tvalid),
    .mac_axis_tlast(tlast), .mac_axis_tuser(tuser), .rtc_timer_in(rtc),
    .mac_axis_out_tdata(o_tdata), .mac_axis_out_tvalid(o_tvalid), .mac_axis_out_tlast(o_tlast),
    .mac_axis_out_tuser(o_tuser), .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_time(ts_time),
    .ts_seq_id(ts_seq_id), .ts_msg_type(ts_msg_type), .ts_overflow(ts_overflow),
    .ts_drop_count(ts_drop_count));

  // Second instance with a latency that forces the 64-bit add to wrap.
  tsu_axis_rx #(.FIFO_DEPTH(DEPTH), .TS_LATENCY_NS(LAT_B), .PTP_ETHERTYPE(16'h88F7)) dut_lat (
    .mac_axis_aclk(clk), .rst_n(rst_n), .mac_axis_tdata(tdata), .mac_axis_tvalid(tvalid),
    .mac_axis_tlast(tlast), .mac_axis_tuser(tuser), .rtc_timer_in(rtc),
    .mac_axis_out_tdata(b_tdata), .mac_axis_out_tvalid(b_tvalid), .mac_axis_out_tlast(b_tlast),
    .mac_axis_out_tuser(b_tuser), .ts_valid(b_valid), .ts_ready(ts_ready), .ts_time(b_time),
    .ts_seq_id(b_seq_id), .ts_msg_type(b_msg_type), .ts_overflow(b_overflow),
    .ts_drop_count(b_drop_count));

  typedef struct {
    logic [3:0]  msg;
    logic [15:0] seq;
    logic [63:0] t;
  } ent_t;

  ent_t        q[$];
  logic        exp_ovf;
  logic [15:0] exp_drop;
  logic [7:0]  e_td;
  logic        e_tv, e_tl, e_tu;
  logic [63:0] rtc_now;
  logic [7:0]  fb [128];
  bit          rand_ready;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("pt_tdata", 64'(o_tdata), 64'(e_td));
    chk("pt_tvalid", 64'(o_tvalid), 64'(e_tv));
    chk("pt_tlast", 64'(o_tlast), 64'(e_tl));
    chk("pt_tuser", 64'(o_tuser), 64'(e_tu));
    chk("ts_valid", 64'(ts_valid), 64'(q.size() != 0));
    chk("ts_valid_lat", 64'(b_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("ts_time", ts_time, q[0].t);
      chk("ts_seq_id", 64'(ts_seq_id), 64'(q[0].seq));
      chk("ts_msg_type", 64'(ts_msg_type), 64'(q[0].msg));
      chk("ts_time_lat", b_time, q[0].t + LAT_B);
    end
    chk("ts_overflow", 64'(ts_overflow), 64'(exp_ovf));
    chk("ts_drop_count", 64'(ts_drop_count), 64'(exp_drop));
  endtask

  // One clock: check state, drive a beat, then advance the model across the edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic l, input logic u,
                      input bit push, input ent_t e);
    bit pop, full;
    check_outputs();
    if (rand_ready) ts_ready = 1'($urandom_range(0, 1));
    tvalid = v; tdata = d; tlast = l; tuser = u; rtc = rtc_now;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      exp_ovf = 1'b0; exp_drop = '0;
      e_td = '0; e_tv = 1'b0; e_tl = 1'b0; e_tu = 1'b0;
    end else begin
      e_td = d; e_tv = v; e_tl = l; e_tu = u;
      full = (q.size() == DEPTH);
      pop  = (q.size() != 0) && ts_ready;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (!full || pop) q.push_back(e);
        else begin
          exp_ovf = 1'b1;
          if (exp_drop != 16'hFFFF) exp_drop++;
        end
      end
    end
    rtc_now = rtc_now + 64'd8;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    ent_t z;
    z.msg = '0; z.seq = '0; z.t = '0;
    repeat (n) tick(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, z);
  endtask

  // vl: 0 untagged, 1 single tag, 2 double tag
  task automatic build(input logic [15:0] eth, input logic [7:0] mb, input logic [15:0] seq,
                       input int vl);
    int off;
    for (int i = 0; i < 128; i++) fb[i] = 8'($urandom);
    off = (vl != 0) ? 4 : 0;
    if (vl != 0) begin fb[12] = 8'h81; fb[13] = 8'h00; end
    fb[12+off] = eth[15:8]; fb[13+off] = eth[7:0];
    if (vl == 2) begin fb[16] = 8'h81; fb[17] = 8'h00; end
    fb[14+off] = mb; fb[44+off] = seq[15:8]; fb[45+off] = seq[7:0];
  endtask

  task automatic send_frame(input int len, input bit u, input bit gaps, input int rst_at,
                            input bit rdy_last);
    ent_t        e, z;
    int          off;
    logic [15:0] eth;
    logic [7:0]  mb;
    bit          ok, aborted;
    z.msg = '0; z.seq = '0; z.t = '0;
    off = 0;
    eth = {fb[12], fb[13]};
    if (VLAN_EN && eth == 16'h8100) begin off = 4; eth = {fb[16], fb[17]}; end
    mb  = fb[14+off];
    ok  = (len >= 46 + off) && (eth == 16'h88F7) && (mb[3:0] <= 4'd3) && !u;
    e.msg = mb[3:0]; e.seq = {fb[44+off], fb[45+off]}; e.t = '0;
    aborted = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) tick(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, z);
      if (i == 0) e.t = rtc_now;
      if (i == rst_at) begin rst_n = 1'b0; aborted = 1'b1; end
      if (rdy_last && i == len - 1) ts_ready = 1'b1;
      tick(1'b1, fb[i], i == len - 1, (i == len - 1) ? u : 1'($urandom),
           ok && !aborted && (i == len - 1), e);
      rst_n = 1'b1;
      if (rdy_last && i == len - 1) ts_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0; tuser = 1'b0; rtc = '0;
    ts_ready = 1'b0; rand_ready = 1'b0; rtc_now = 64'd500;
    exp_ovf = 1'b0; exp_drop = '0; e_td = '0; e_tv = 1'b0; e_tl = 1'b0; e_tu = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(ts_valid), 64'd0);
    chk("rst_time", ts_time, 64'd0);
    chk("rst_seq", 64'(ts_seq_id), 64'd0);
    chk("rst_msg", 64'(ts_msg_type), 64'd0);
    chk("rst_ovf", 64'(ts_overflow), 64'd0);
    chk("rst_drop", 64'(ts_drop_count), 64'd0);
    chk("rst_pt_tvalid", 64'(o_tvalid), 64'd0);
    rst_n = 1'b1;
    idle(3);

    // basic PTP Sync frame
    rtc_now = 64'd1000;
    build(16'h88F7, 8'h00, 16'h1234, 0);
    send_frame(61, 1'b0, 1'b0, -1, 1'b0);
    chk("t1_valid", 64'(ts_valid), 64'd1);
    chk("t1_time", ts_time, 64'd1000);
    chk("t1_seq", 64'(ts_seq_id), 64'h1234);
    chk("t1_msg", 64'(ts_msg_type), 64'd0);
    chk("t1_time_lat", b_time, 64'd1000 + LAT_B);
    ts_ready = 1'b1; idle(2); ts_ready = 1'b0;

    // non-event message, non-PTP EtherType, bad frame, short frame
    build(16'h88F7, 8'h0B, 16'h2222, 0);
    send_frame(61, 1'b0, 1'b0, -1, 1'b0);
    chk("t2_announce", 64'(ts_valid), 64'd0);
    build(16'h0800, 8'h00, 16'h2223, 0);
    send_frame(61, 1'b0, 1'b0, -1, 1'b0);
    chk("t2_ipv4", 64'(ts_valid), 64'd0);
    build(16'h88F7, 8'h01, 16'h3333, 0);
    send_frame(61, 1'b1, 1'b1, -1, 1'b0);
    chk("t3_tuser", 64'(ts_valid), 64'd0);
    build(16'h88F7, 8'h00, 16'h3334, 0);
    send_frame(40, 1'b0, 1'b0, -1, 1'b0);
    chk("t3_short", 64'(ts_valid), 64'd0);
    idle(2);

    // overflow with consumer stalled, then in-order drain
    for (int k = 1; k <= 6; k++) begin
      build(16'h88F7, 8'(k % 4), 16'(k), 0);
      send_frame(61, 1'b0, 1'b0, -1, 1'b0);
    end
    chk("t4_ovf", 64'(ts_overflow), 64'd1);
    chk("t4_drop", 64'(ts_drop_count), 64'd2);
    ts_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t4_order", 64'(ts_seq_id), 64'(k));
      idle(1);
    end
    chk("t4_empty", 64'(ts_valid), 64'd0);
    ts_ready = 1'b0;

    // reset in the middle of a frame, then a clean frame
    build(16'h88F7, 8'h00, 16'h5555, 0);
    send_frame(61, 1'b0, 1'b0, 20, 1'b0);
    chk("t5_abort", 64'(ts_valid), 64'd0);
    chk("t5_ovf_clr", 64'(ts_overflow), 64'd0);
    build(16'h88F7, 8'h02, 16'h6666, 0);
    send_frame(61, 1'b0, 1'b0, -1, 1'b0);
    chk("t5_valid", 64'(ts_valid), 64'd1);
    chk("t5_seq", 64'(ts_seq_id), 64'h6666);
    ts_ready = 1'b1; idle(2); ts_ready = 1'b0;

    // full FIFO with a pop on the push cycle: nothing dropped
    for (int k = 0; k < 5; k++) begin
      build(16'h88F7, 8'h01, 16'h0010 + 16'(k), 0);
      send_frame(50, 1'b0, 1'b0, -1, k == 4);
    end
    chk("tf_drop", 64'(ts_drop_count), 64'd0);
    chk("tf_ovf", 64'(ts_overflow), 64'd0);
    ts_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("tf_order", 64'(ts_seq_id), 64'h0010 + 64'(k));
      idle(1);
    end
    ts_ready = 1'b0;

    // single VLAN tag
    build(16'h88F7, 8'h03, 16'hABCD, 1);
    send_frame(64, 1'b0, 1'b0, -1, 1'b0);
    chk("t6_vlan", 64'(ts_valid), 64'(VLAN_EN));
    ts_ready = 1'b1; idle(2); ts_ready = 1'b0;

    rand_ready = 1'b1;
    for (int f = 0; f < 45; f++) begin
      int          k, len;
      logic [7:0]  mb;
      logic [15:0] seq;
      bit          u, gp;
      k   = $urandom_range(0, 9);
      seq = 16'($urandom);
      mb  = {4'($urandom), 4'($urandom_range(0, 3))};
      u   = ($urandom_range(0, 5) == 0);
      gp  = 1'($urandom_range(0, 1));
      len = $urandom_range(46, 90);
      if ($urandom_range(0, 4) == 0) rtc_now = {32'($urandom), 32'($urandom)};
      case (k)
        5: begin mb[3:0] = 4'($urandom_range(4, 15)); build(16'h88F7, mb, seq, 0); end
        6: build(16'h0800, mb, seq, 0);
        7: begin len = $urandom_range(50, 90); build(16'h88F7, mb, seq, 1); end
        8: begin len = $urandom_range(1, 45); build(16'h88F7, mb, seq, 0); end
        9: build(16'h88F7, mb, seq, 2);
        default: build(16'h88F7, mb, seq, 0);
      endcase
      send_frame(len, u, gp, -1, 1'b0);
      idle($urandom_range(0, 3));
    end
    rand_ready = 1'b0;
    ts_ready = 1'b1;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
